uart_tx_feeder: RTL and testbench

Byte-buffering front end that sits directly upstream of the UART transmitter. It accepts bytes from system logic over a valid/ready write port and stores them in a FIFO. It issues the bytes one at a time to the transmitter through its data-valid/byte inputs, pacing each issue on the transmitter's done indication. The block lets the rest of the design (sensor/display logging) enqueue bursts without tracking serial timing.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_byte_fifo.sv | 77 +++++++
 rtl/uart_tx_feeder.sv | 108 ++++++++++
 tb/tb_uart_tx_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with occupancy count and synchronous flush.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] push_data_i,
    input  logic                   pop_i,
    output logic [UART_DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Flush wins over both ports; a full FIFO refuses a push even if it pops.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes from system logic and issues them one at a time to the UART
// transmitter, pacing each issue on the transmitter's done indication.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_valid,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    output logic                   o_wr_ready,
    input  logic                   i_flush,
    output logic                   o_TX_DV,
    output logic [UART_DATA_W-1:0] o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic [CNT_W-1:0]       o_count,
    output logic                   o_busy,
    output logic                   o_overflow
);

    feeder_state_t          state_q;
    logic                   done_q;
    logic                   dv_q;
    logic [UART_DATA_W-1:0] byte_q;
    logic                   ovf_q;

    logic                   done_rise;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]       fifo_count;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (i_flush),
        .push_i      (i_wr_valid),
        .push_data_i (i_wr_data),
        .pop_i       (fifo_pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Done may be held for several cycles; only its rising edge advances the FSM.
    assign done_rise = i_TX_Done && !done_q;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !i_TX_Active && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
        end else begin
            done_q <= i_TX_Done;
            dv_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        byte_q  <= fifo_head;
                        dv_q    <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (i_flush) begin
            ovf_q <= 1'b0;
        end else if (i_wr_valid && fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_wr_ready = !fifo_full;
    assign o_TX_DV    = dv_q;
    assign o_TX_Byte  = byte_q;
    assign o_count    = fifo_count;
    assign o_busy     = (state_q != IDLE) || (fifo_count != '0);
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus a randomized
// phase, checked against a cycle-level behavioural model of the feeder.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_wr_valid = 1'b0;
    logic [7:0]       i_wr_data = 8'h00;
    logic             o_wr_ready;
    logic             i_flush = 1'b0;
    logic             o_TX_DV;
    logic [7:0]       o_TX_Byte;
    logic             i_TX_Active = 1'b0;
    logic             i_TX_Done = 1'b0;
    logic [CNT_W-1:0] o_count;
    logic             o_busy;
    logic             o_overflow;

    uart_tx_feeder #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_valid  (i_wr_valid),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .i_flush     (i_flush),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_count     (o_count),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queued bytes, bytes issued, bytes seen by the transmitter.
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] cap[$];
    int         cyc;
    int         issue_cyc;
    int         done_cyc;
    int         earliest;
    bit         in_flight;
    bit         m_ovf;
    bit         prev_done;
    logic [7:0] m_byte;

    // Transmitter model knobs and state.
    int tx_busy;
    int tx_done;
    int busy_len = 4;
    int hold_len = 1;
    bit stall = 1'b0;
    bit spurious = 1'b0;

    int last_rise = -1;
    int first_dv = -1;
    int max_count = 0;
    int dv_n = 0;
    bit check_gap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sent.delete();
        cap.delete();
        cyc = 0;
        issue_cyc = -10;
        done_cyc = -10;
        earliest = 0;
        in_flight = 1'b0;
        m_ovf = 1'b0;
        prev_done = 1'b0;
        m_byte = 8'h00;
        tx_busy = 0;
        tx_done = 0;
        i_wr_valid = 1'b0;
        i_flush = 1'b0;
        i_TX_Active = 1'b0;
        i_TX_Done = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
        chk({tag, "_ready"}, 32'(o_wr_ready), 32'd1);
        chk({tag, "_dv"}, 32'(o_TX_DV), 32'd0);
        chk({tag, "_byte"}, 32'(o_TX_Byte), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
    endtask

    task automatic clear_log();
        sent.delete();
        cap.delete();
        dv_n = 0;
        first_dv = -1;
        max_count = 0;
        last_rise = -1;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit f);
        bit elig;
        bit full;
        bit rise;
        i_wr_valid = v;
        i_wr_data = d;
        i_flush = f;
        if (tx_busy > 0) begin
            i_TX_Active = 1'b1;
            i_TX_Done = 1'b0;
            if (!stall) begin
                tx_busy--;
                if (tx_busy == 0) tx_done = hold_len;
            end
        end else if (tx_done > 0) begin
            i_TX_Active = 1'b0;
            i_TX_Done = 1'b1;
            tx_done--;
        end else begin
            i_TX_Active = spurious && ($urandom_range(0, 15) == 0);
            i_TX_Done = spurious && ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        chk("count", 32'(o_count), 32'(mq.size()));
        chk("wr_ready", 32'(o_wr_ready), 32'(mq.size() < DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("tx_dv", 32'(o_TX_DV), 32'(cyc == issue_cyc));
        chk("tx_byte", 32'(o_TX_Byte), 32'(m_byte));
        chk("busy", 32'(o_busy), 32'(in_flight || cyc == done_cyc + 1 || mq.size() != 0));
        if (32'(o_count) > 32'(max_count)) max_count = int'(o_count);
        if (o_TX_DV) begin
            cap.push_back(o_TX_Byte);
            dv_n++;
            if (first_dv < 0) first_dv = cyc;
            if (check_gap && last_rise >= 0) chk("dv_after_done", 32'(cyc - last_rise), 32'd3);
            last_rise = -1;
            tx_busy = busy_len;
            tx_done = 0;
        end
        rise = i_TX_Done && !prev_done;
        prev_done = i_TX_Done;
        if (rise) last_rise = cyc;
        full = (mq.size() == DEPTH);
        elig = !in_flight && cyc >= earliest && mq.size() > 0 && !i_TX_Active && !f;
        // A byte is complete on the first done edge after its issue cycle.
        if (in_flight && cyc > issue_cyc && rise) begin
            in_flight = 1'b0;
            done_cyc = cyc;
            earliest = cyc + 2;
        end
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (v && full) m_ovf = 1'b1;
            if (elig) begin
                m_byte = mq.pop_front();
                sent.push_back(m_byte);
                in_flight = 1'b1;
                issue_cyc = cyc + 1;
            end
            if (v && !full) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((in_flight || mq.size() != 0 || cyc <= done_cyc + 1 || tx_busy > 0 || tx_done > 0)
               && n < 3000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk({tag, "_drain_bound"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_sent(input string tag);
        chk({tag, "_n"}, 32'(cap.size()), 32'(sent.size()));
        for (int i = 0; i < cap.size() && i < sent.size(); i++) begin
            chk(tag, 32'(cap[i]), 32'(sent[i]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte written at cycle 10 must be issued at cycle 12.
        clear_log();
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        drain("single");
        chk("single_dv_cycle", 32'(first_dv), 32'd12);
        chk("single_dv_n", 32'(dv_n), 32'd1);
        chk("single_byte", 32'(cap[0]), 32'hA5);
        chk("single_busy_end", 32'(o_busy), 32'd0);

        // Burst of five bytes.
        clear_log();
        check_gap = 1'b1;
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
        drain("burst");
        check_gap = 1'b0;
        chk("burst_dv_n", 32'(dv_n), 32'd5);
        for (int i = 0; i < 5; i++) chk("burst_order", 32'(cap[i]), 32'(i + 1));
        chk("burst_max_count", 32'(max_count), 32'd4);

        // Fill with the transmitter stalled, then overflow.
        clear_log();
        stall = 1'b1;
        step(1'b1, 8'h10, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        chk("full_count", 32'(o_count), 32'd16);
        chk("full_ready", 32'(o_wr_ready), 32'd0);
        step(1'b1, 8'h99, 1'b0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd16);

        // Release: a write held across the pop is accepted only once ready returns.
        stall = 1'b0;
        begin
            int n = 0;
            while (mq.size() == DEPTH && n < 100) begin
                step(1'b1, 8'hEE, 1'b0);
                n++;
            end
            chk("full_pop_bound", 32'(n < 100), 32'd1);
        end
        step(1'b1, 8'hEE, 1'b0);
        chk("refill_count", 32'(o_count), 32'd16);
        drain("full");
        check_sent("full");
        chk("full_total", 32'(cap.size()), 32'd18);
        chk("full_oldest", 32'(cap[1]), 32'h20);
        chk("full_last", 32'(cap[17]), 32'hEE);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // Flush while a byte is in flight.
        clear_log();
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        dv_n = 0;
        step(1'b1, 8'h77, 1'b1);
        chk("flush_count", 32'(o_count), 32'd0);
        chk("flush_ovf", 32'(o_overflow), 32'd0);
        chk("flush_busy", 32'(o_busy), 32'd1);
        stall = 1'b0;
        drain("flush");
        chk("flush_no_dv", 32'(dv_n), 32'd0);
        chk("flush_idle", 32'(o_busy), 32'd0);

        // Stretched done: one advance per done edge.
        clear_log();
        hold_len = 4;
        check_gap = 1'b1;
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h43, 1'b0);
        drain("stretch");
        check_gap = 1'b0;
        hold_len = 1;
        chk("stretch_dv_n", 32'(dv_n), 32'd3);
        check_sent("stretch");

        // Randomized traffic with flushes and spurious transmitter activity.
        clear_log();
        spurious = 1'b1;
        for (int i = 0; i < 800; i++) begin
            busy_len = $urandom_range(1, 8);
            hold_len = $urandom_range(1, 4);
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 49) == 0));
        end
        spurious = 1'b0;
        busy_len = 4;
        hold_len = 1;
        drain("random");
        check_sent("random");

        // Reset in the middle of a transfer.
        clear_log();
        stall = 1'b1;
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h56, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset("midreset");
        model_reset();
        clear_log();
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h66, 1'b0);
        drain("post_reset");
        check_sent("post_reset");
        chk("post_reset_byte", 32'(cap[0]), 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
